// File: rtl/serial_adder_pkg.sv
// -----------------------------------------------------------------------------
// serial_adder_pkg
// Shared definitions for the bit-serial adder.
//   - state_t : FSM state encoding (IDLE=0, RUN=1, DONE=2)
// -----------------------------------------------------------------------------
package serial_adder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage : serial_adder_pkg

// File: rtl/serial_adder_fa_bit_cell.sv
// -----------------------------------------------------------------------------
// fa_bit_cell
// Purely combinational 1-bit full adder built from two half-add stages.
// Ports:
//   a, b, ci : input bits
//   s        : sum bit
//   co       : carry-out bit
// -----------------------------------------------------------------------------
module fa_bit_cell (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    logic ha0_s_s;
    logic ha0_c_s;
    logic ha1_c_s;

    // First half-add stage: a + b
    assign ha0_s_s = a ^ b;
    assign ha0_c_s = a & b;

    // Second half-add stage: (a ^ b) + ci, carries merged with OR
    assign s       = ha0_s_s ^ ci;
    assign ha1_c_s = ha0_s_s & ci;
    assign co      = ha0_c_s | ha1_c_s;

endmodule : fa_bit_cell

// File: rtl/serial_adder.sv
// -----------------------------------------------------------------------------
// serial_adder
// Bit-serial WIDTH-bit adder, LSB first, one bit per clock through a single
// full-adder cell with a registered carry. {cout,sum} = a + b + cin.
// Ports:
//   clk   : clock, rising edge
//   rst   : synchronous active-high reset
//   start : request, accepted only in IDLE or DONE
//   a, b  : operands, captured on the accepted start edge
//   cin   : carry-in, captured on the accepted start edge
//   busy  : high while the operation is running
//   done  : one-cycle pulse, sum/cout valid in this cycle
//   sum   : result register (holds previous result until the next DONE)
//   cout  : final carry-out register
// -----------------------------------------------------------------------------
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CNT_W = $clog2(WIDTH);

    state_t             state_r;
    state_t             state_next_s;
    logic [WIDTH-1:0]   sha_r;
    logic [WIDTH-1:0]   shb_r;
    logic [WIDTH-1:0]   part_r;
    logic [WIDTH-1:0]   sum_r;
    logic [CNT_W-1:0]   cnt_r;
    logic               carry_r;
    logic               cout_r;
    logic               busy_r;
    logic               done_r;
    logic               load_s;
    logic               last_s;
    logic               cell_s_s;
    logic               cell_co_s;
    logic [WIDTH-1:0]   part_next_s;

    fa_bit_cell u_fa (
        .a  (sha_r[0]),
        .b  (shb_r[0]),
        .ci (carry_r),
        .s  (cell_s_s),
        .co (cell_co_s)
    );

    // The new sum bit enters at the MSB so after WIDTH shifts the LSB lands at bit 0
    assign part_next_s = {cell_s_s, part_r[WIDTH-1:1]};
    assign last_s      = (cnt_r == CNT_W'(WIDTH - 1));

    // Next-state logic and start acceptance
    always_comb begin
        state_next_s = state_r;
        load_s       = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_next_s = ST_RUN;
                    load_s       = 1'b1;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (last_s) begin
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_RUN;
                end
            end
            ST_DONE: begin
                if (start) begin
                    state_next_s = ST_RUN;
                    load_s       = 1'b1;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
                load_s       = 1'b0;
            end
        endcase
    end

    // State, datapath and registered status outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            sha_r   <= '0;
            shb_r   <= '0;
            part_r  <= '0;
            sum_r   <= '0;
            cnt_r   <= '0;
            carry_r <= 1'b0;
            cout_r  <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_next_s;
            busy_r  <= (state_next_s == ST_RUN);
            done_r  <= (state_next_s == ST_DONE);
            if (load_s) begin
                sha_r   <= a;
                shb_r   <= b;
                carry_r <= cin;
                part_r  <= '0;
                cnt_r   <= '0;
            end else if (state_r == ST_RUN) begin
                sha_r   <= {1'b0, sha_r[WIDTH-1:1]};
                shb_r   <= {1'b0, shb_r[WIDTH-1:1]};
                carry_r <= cell_co_s;
                part_r  <= part_next_s;
                if (last_s) begin
                    // Counter parks at its terminal value; the next load clears it
                    sum_r  <= part_next_s;
                    cout_r <= cell_co_s;
                end else begin
                    cnt_r <= cnt_r + CNT_W'(1);
                end
            end
        end
    end

    assign busy = busy_r;
    assign done = done_r;
    assign sum  = sum_r;
    assign cout = cout_r;

endmodule : serial_adder

// File: tb/tb_serial_adder.sv
// -----------------------------------------------------------------------------
// tb_serial_adder
// Self-checking bench for serial_adder (WIDTH=8): a table of directed vectors,
// randomized operands against an arithmetic reference, and hand-written
// sequences for start-while-busy, reset mid-run and back-to-back operation.
// -----------------------------------------------------------------------------
module tb_serial_adder;

    localparam int W = 8;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic [W-1:0] exp_sum;
        logic         exp_cout;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;

    int n_cmp  = 0;
    int n_fail = 0;

    serial_adder #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Present operands with start for one edge, then scramble the don't-care inputs
    task automatic start_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic cv);
        start = 1'b1;
        a     = av;
        b     = bv;
        cin   = cv;
        tick();
        start = 1'b0;
        a     = W'($urandom);
        b     = W'($urandom);
        cin   = 1'($urandom);
    endtask

    // Wait (bounded) for done; optionally pulse start with 0x11 operands at cycle inj_at
    task automatic wait_done(input int inj_at, output int cyc, output int bcnt, output bit unstable);
        logic [W-1:0] ps;
        logic         pc;
        ps       = sum;
        pc       = cout;
        cyc      = 0;
        bcnt     = 0;
        unstable = 1'b0;
        while (done !== 1'b1 && cyc < 40) begin
            if (busy === 1'b1) bcnt++;
            if (sum !== ps || cout !== pc) unstable = 1'b1;
            if (cyc == inj_at) begin
                start = 1'b1;
                a     = 8'h11;
                b     = 8'h11;
            end else begin
                start = 1'b0;
            end
            tick();
            cyc++;
        end
        start = 1'b0;
    endtask

    // Full operation with latency, busy-width, stability and result checks
    task automatic run_op(input string name, input logic [W-1:0] av, input logic [W-1:0] bv,
                          input logic cv, input logic [W-1:0] es, input logic ec, input int inj_at);
        int cyc;
        int bcnt;
        bit unstable;
        start_op(av, bv, cv);
        wait_done(inj_at, cyc, bcnt, unstable);
        check({name, "_done_seen"}, 32'(done), 32'd1);
        check({name, "_latency"}, 32'(cyc), 32'(W));
        check({name, "_busy_cycles"}, 32'(bcnt), 32'(W));
        check({name, "_sum_held"}, 32'(unstable), 32'd0);
        check({name, "_busy_at_done"}, 32'(busy), 32'd0);
        check({name, "_sum"}, 32'(sum), 32'(es));
        check({name, "_cout"}, 32'(cout), 32'(ec));
        tick();
        check({name, "_done_pulse_1cyc"}, 32'(done), 32'd0);
    endtask

    vec_t vecs[4];

    initial begin
        int           seen;
        int           cyc;
        int           bcnt;
        bit           unstable;
        logic [W:0]   model;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic         rc;

        vecs[0] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
        vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
        vecs[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
        vecs[3] = '{8'h5A, 8'h3C, 1'b1, 8'h97, 1'b0};

        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        cin   = 1'b0;
        tick();
        tick();
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_sum", 32'(sum), 32'd0);
        check("reset_cout", 32'(cout), 32'd0);
        rst = 1'b0;
        tick();

        // Directed table
        for (int i = 0; i < 4; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].cin,
                   vecs[i].exp_sum, vecs[i].exp_cout, -1);
        end

        // Random operands against plain arithmetic
        for (int i = 0; i < 25; i++) begin
            ra    = W'($urandom);
            rb    = W'($urandom);
            rc    = 1'($urandom);
            model = {1'b0, ra} + {1'b0, rb} + {{W{1'b0}}, rc};
            run_op($sformatf("rand%0d", i), ra, rb, rc, model[W-1:0], model[W], -1);
            if ($urandom_range(0, 1) == 0) tick();
        end

        // Start while busy: the 0x11 request at cycle 3 must be ignored
        run_op("busy_start", 8'h40, 8'h22, 1'b0, 8'h62, 1'b0, 3);
        seen = 0;
        for (int k = 0; k < W + 4; k++) begin
            if (done === 1'b1) seen++;
            tick();
        end
        check("busy_start_no_extra_done", 32'(seen), 32'd0);

        // Reset at cycle 4 of RUN aborts: sum returns to 0, no done pulse
        start_op(8'hAB, 8'h12, 1'b1);
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_mid_busy", 32'(busy), 32'd0);
        check("rst_mid_sum", 32'(sum), 32'd0);
        check("rst_mid_cout", 32'(cout), 32'd0);
        check("rst_mid_done", 32'(done), 32'd0);
        seen = 0;
        for (int k = 0; k < W + 4; k++) begin
            if (done === 1'b1 || busy === 1'b1) seen++;
            tick();
        end
        check("rst_mid_stays_idle", 32'(seen), 32'd0);

        // Back-to-back: start held in the DONE cycle re-enters RUN immediately
        start_op(8'h10, 8'h20, 1'b0);
        wait_done(-1, cyc, bcnt, unstable);
        check("b2b_first_done", 32'(done), 32'd1);
        check("b2b_first_sum", 32'(sum), 32'h30);
        start = 1'b1;
        a     = 8'h01;
        b     = 8'h02;
        cin   = 1'b0;
        tick();
        start = 1'b0;
        a     = 8'hEE;
        b     = 8'hEE;
        check("b2b_rerun_busy", 32'(busy), 32'd1);
        check("b2b_rerun_done", 32'(done), 32'd0);
        wait_done(-1, cyc, bcnt, unstable);
        check("b2b_second_done", 32'(done), 32'd1);
        check("b2b_second_latency", 32'(cyc), 32'(W));
        check("b2b_first_sum_held", 32'(unstable), 32'd0);
        check("b2b_second_sum", 32'(sum), 32'h03);
        check("b2b_second_cout", 32'(cout), 32'd0);
        tick();
        check("b2b_idle_after", 32'(busy | done), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule : tb_serial_adder
